// File: rtl/uart_pkt_decoder_pkg.sv
// Shared types and width helpers for the UART packet decoder.
package uart_pkt_decoder_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CMD     = 3'd1,
        ST_LEN     = 3'd2,
        ST_PAYLOAD = 3'd3,
        ST_CHK     = 3'd4,
        ST_HOLD    = 3'd5
    } state_t;

    localparam logic [7:0] SYNC_DEFAULT = 8'hA5;

    function automatic int len_width(input int max_payload);
        return $clog2(max_payload + 1);
    endfunction

    function automatic int addr_width(input int max_payload);
        return (max_payload > 1) ? $clog2(max_payload) : 1;
    endfunction

endpackage

// File: rtl/uart_pkt_decoder_buffer.sv
// Payload store: one synchronous write port, one asynchronous read port, no reset.
module uart_pkt_decoder_buffer #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clock,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data
);

    logic [7:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Addresses past the depth read as zero rather than indexing outside the array.
    assign rd_data = (int'(rd_addr) < DEPTH) ? mem[rd_addr] : 8'h00;

endmodule

// File: rtl/uart_pkt_decoder.sv
// Framed command packet decoder fed by a UART receiver byte stream.
// state   | meaning
// IDLE    | hunting for the sync byte
// CMD     | expecting the command byte
// LEN     | expecting the payload length
// PAYLOAD | collecting payload bytes into the buffer
// CHK     | expecting the XOR checksum
// HOLD    | verified packet presented until acknowledged
module uart_pkt_decoder
    import uart_pkt_decoder_pkg::*;
#(
    parameter int         MAX_PAYLOAD    = 16,
    parameter logic [7:0] SYNC_BYTE      = SYNC_DEFAULT,
    parameter int         TIMEOUT_CLOCKS = 1024,
    localparam int        LW             = len_width(MAX_PAYLOAD),
    localparam int        AW             = addr_width(MAX_PAYLOAD)
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic [7:0]    byte_i,
    input  logic          byte_valid_i,
    output logic          pkt_valid_o,
    output logic [7:0]    pkt_cmd_o,
    output logic [LW-1:0] pkt_len_o,
    input  logic [AW-1:0] rd_addr_i,
    output logic [7:0]    rd_data_o,
    input  logic          pkt_ack_i,
    output logic          err_checksum_o,
    output logic          err_length_o,
    output logic          err_timeout_o,
    output logic          err_overrun_o
);

    localparam int            TW       = (TIMEOUT_CLOCKS > 1) ? $clog2(TIMEOUT_CLOCKS) : 1;
    localparam logic [TW-1:0] TMR_LOAD = TW'((TIMEOUT_CLOCKS > 0) ? TIMEOUT_CLOCKS - 1 : 0);

    state_t          state_q, state_d;
    logic [7:0]      cmd_q, xor_q;
    logic [LW-1:0]   len_q, idx_q;
    logic [TW-1:0]   tmr_q;
    logic            err_chk_d, err_len_d, err_tmo_d, err_ovr_d;
    logic            in_frame, tmr_expired, len_too_long, last_payload;
    logic            buf_we;
    logic [7:0]      buf_rd;

    assign in_frame     = (state_q == ST_CMD) || (state_q == ST_LEN) ||
                          (state_q == ST_PAYLOAD) || (state_q == ST_CHK);
    // A byte landing on the expiry cycle takes priority over the timeout.
    assign tmr_expired  = (TIMEOUT_CLOCKS != 0) && in_frame && !byte_valid_i && (tmr_q == '0);
    assign len_too_long = int'(byte_i) > MAX_PAYLOAD;
    assign last_payload = (idx_q + LW'(1)) == len_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= ST_IDLE;
            err_checksum_o <= 1'b0;
            err_length_o   <= 1'b0;
            err_timeout_o  <= 1'b0;
            err_overrun_o  <= 1'b0;
        end else begin
            state_q        <= state_d;
            err_checksum_o <= err_chk_d;
            err_length_o   <= err_len_d;
            err_timeout_o  <= err_tmo_d;
            err_overrun_o  <= err_ovr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        err_chk_d = 1'b0;
        err_len_d = 1'b0;
        err_tmo_d = 1'b0;
        err_ovr_d = 1'b0;
        if (tmr_expired) begin
            state_d   = ST_IDLE;
            err_tmo_d = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (byte_valid_i && (byte_i == SYNC_BYTE)) state_d = ST_CMD;
                end
                ST_CMD: begin
                    if (byte_valid_i) state_d = ST_LEN;
                end
                ST_LEN: begin
                    if (byte_valid_i) begin
                        if (len_too_long) begin
                            state_d   = ST_IDLE;
                            err_len_d = 1'b1;
                        end else if (byte_i == 8'h00) begin
                            state_d = ST_CHK;
                        end else begin
                            state_d = ST_PAYLOAD;
                        end
                    end
                end
                ST_PAYLOAD: begin
                    if (byte_valid_i && last_payload) state_d = ST_CHK;
                end
                ST_CHK: begin
                    if (byte_valid_i) begin
                        if (byte_i == xor_q) begin
                            state_d = ST_HOLD;
                        end else begin
                            state_d   = ST_IDLE;
                            err_chk_d = 1'b1;
                        end
                    end
                end
                ST_HOLD: begin
                    err_ovr_d = byte_valid_i;
                    if (pkt_ack_i) state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        pkt_valid_o = (state_q == ST_HOLD);
        buf_we      = byte_valid_i && (state_q == ST_PAYLOAD);
        pkt_cmd_o   = cmd_q;
        pkt_len_o   = len_q;
        rd_data_o   = pkt_valid_o ? buf_rd : 8'h00;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cmd_q <= 8'h00;
            xor_q <= 8'h00;
            len_q <= '0;
            idx_q <= '0;
            tmr_q <= '0;
        end else begin
            if (byte_valid_i) begin
                tmr_q <= TMR_LOAD;
            end else if (in_frame && (tmr_q != '0)) begin
                tmr_q <= tmr_q - TW'(1);
            end
            if (byte_valid_i) begin
                case (state_q)
                    ST_CMD: begin
                        cmd_q <= byte_i;
                        xor_q <= byte_i;
                    end
                    ST_LEN: begin
                        if (!len_too_long) begin
                            len_q <= LW'(byte_i);
                            xor_q <= xor_q ^ byte_i;
                            idx_q <= '0;
                        end
                    end
                    ST_PAYLOAD: begin
                        xor_q <= xor_q ^ byte_i;
                        idx_q <= idx_q + LW'(1);
                    end
                    default: ;
                endcase
            end
        end
    end

    uart_pkt_decoder_buffer #(
        .DEPTH (MAX_PAYLOAD),
        .AW    (AW)
    ) u_buffer (
        .clock   (clock),
        .wr_en   (buf_we),
        .wr_addr (idx_q[AW-1:0]),
        .wr_data (byte_i),
        .rd_addr (rd_addr_i),
        .rd_data (buf_rd)
    );

endmodule

// File: tb/tb_uart_pkt_decoder.sv
// Directed bench for uart_pkt_decoder with hand-computed frames and checksums.
module tb_uart_pkt_decoder;

    localparam int TMO = 32;

    logic       clock = 1'b0;
    logic       reset_n;
    logic [7:0] byte_i;
    logic       byte_valid_i;
    logic       pkt_valid_o;
    logic [7:0] pkt_cmd_o;
    logic [4:0] pkt_len_o;
    logic [3:0] rd_addr_i;
    logic [7:0] rd_data_o;
    logic       pkt_ack_i;
    logic       err_checksum_o, err_length_o, err_timeout_o, err_overrun_o;

    int n_checks = 0;
    int n_fail   = 0;
    int cnt_chk = 0, cnt_len = 0, cnt_tmo = 0, cnt_ovr = 0;

    uart_pkt_decoder #(
        .MAX_PAYLOAD    (16),
        .SYNC_BYTE      (8'hA5),
        .TIMEOUT_CLOCKS (TMO)
    ) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .byte_i         (byte_i),
        .byte_valid_i   (byte_valid_i),
        .pkt_valid_o    (pkt_valid_o),
        .pkt_cmd_o      (pkt_cmd_o),
        .pkt_len_o      (pkt_len_o),
        .rd_addr_i      (rd_addr_i),
        .rd_data_o      (rd_data_o),
        .pkt_ack_i      (pkt_ack_i),
        .err_checksum_o (err_checksum_o),
        .err_length_o   (err_length_o),
        .err_timeout_o  (err_timeout_o),
        .err_overrun_o  (err_overrun_o)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (err_checksum_o === 1'b1) cnt_chk++;
        if (err_length_o   === 1'b1) cnt_len++;
        if (err_timeout_o  === 1'b1) cnt_tmo++;
        if (err_overrun_o  === 1'b1) cnt_ovr++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clock);
        byte_i       = b;
        byte_valid_i = 1'b1;
        @(negedge clock);
        byte_valid_i = 1'b0;
    endtask

    task automatic check_pkt(input string tag, input logic [7:0] cmd, input logic [4:0] len,
                             input logic [7:0] d0, input logic [7:0] d1);
        check({tag, "_valid"}, pkt_valid_o, 1'b1);
        check({tag, "_cmd"}, pkt_cmd_o, cmd);
        check({tag, "_len"}, pkt_len_o, len);
        if (len >= 5'd1) begin
            rd_addr_i = 4'd0;
            #1 check({tag, "_rd0"}, rd_data_o, d0);
        end
        if (len >= 5'd2) begin
            rd_addr_i = 4'd1;
            #1 check({tag, "_rd1"}, rd_data_o, d1);
        end
    endtask

    task automatic ack_pkt(input string tag);
        @(negedge clock);
        pkt_ack_i = 1'b1;
        check({tag, "_valid_during_ack"}, pkt_valid_o, 1'b1);
        @(negedge clock);
        pkt_ack_i = 1'b0;
        check({tag, "_valid_after_ack"}, pkt_valid_o, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        reset_n      = 1'b0;
        byte_i       = 8'h00;
        byte_valid_i = 1'b0;
        rd_addr_i    = 4'd0;
        pkt_ack_i    = 1'b0;
        repeat (2) @(negedge clock);
        check("rst_valid", pkt_valid_o, 1'b0);
        check("rst_cmd", pkt_cmd_o, 8'h00);
        check("rst_len", pkt_len_o, 5'd0);
        check("rst_rd", rd_data_o, 8'h00);
        check("rst_errs", {err_checksum_o, err_length_o, err_timeout_o, err_overrun_o}, 4'b0000);
        reset_n = 1'b1;

        // good frame, checksum 10^02^11^22 = 21
        send_byte(8'hA5); send_byte(8'h10); send_byte(8'h02);
        send_byte(8'h11); send_byte(8'h22);
        check("t1_valid_before_chk", pkt_valid_o, 1'b0);
        send_byte(8'h21);
        check_pkt("t1", 8'h10, 5'd2, 8'h11, 8'h22);
        ack_pkt("t1");

        // bad checksum
        send_byte(8'hA5); send_byte(8'h10); send_byte(8'h02);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h20);
        check("t2_err_chk_pulse", err_checksum_o, 1'b1);
        @(negedge clock);
        check("t2_err_chk_single", err_checksum_o, 1'b0);
        check("t2_valid", pkt_valid_o, 1'b0);
        #1 check("t2_chk_count", cnt_chk, 1);

        // leading garbage, zero-length payload
        send_byte(8'h00); send_byte(8'hFF); send_byte(8'hA5);
        send_byte(8'h05); send_byte(8'h00); send_byte(8'h05);
        check_pkt("t3", 8'h05, 5'd0, 8'h00, 8'h00);
        ack_pkt("t3");

        // oversize length, then a good frame: 01^01^33 = 33
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h20);
        check("t4_err_len_pulse", err_length_o, 1'b1);
        @(negedge clock);
        check("t4_err_len_single", err_length_o, 1'b0);
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h01);
        send_byte(8'h33); send_byte(8'h33);
        check_pkt("t4", 8'h01, 5'd1, 8'h33, 8'h00);
        ack_pkt("t4");

        // length 17 rejected, length 16 accepted: 03^10^(xor 0..15 = 0) = 13
        send_byte(8'hA5); send_byte(8'h03); send_byte(8'h11);
        check("t4b_len17_err", err_length_o, 1'b1);
        send_byte(8'hA5); send_byte(8'h03); send_byte(8'h10);
        for (int i = 0; i < 16; i++) send_byte(8'(i));
        send_byte(8'h13);
        check("t4b_valid", pkt_valid_o, 1'b1);
        check("t4b_len", pkt_len_o, 5'd16);
        rd_addr_i = 4'd15;
        #1 check("t4b_rd15", rd_data_o, 8'h0F);
        rd_addr_i = 4'd7;
        #1 check("t4b_rd7", rd_data_o, 8'h07);
        ack_pkt("t4b");
        #1 check("t4b_len_count", cnt_len, 2);

        // timeout: fires exactly TMO clocks after the last byte
        send_byte(8'hA5); send_byte(8'h01);
        repeat (TMO - 1) @(negedge clock);
        check("t5_no_early_tmo", err_timeout_o, 1'b0);
        @(negedge clock);
        check("t5_tmo_pulse", err_timeout_o, 1'b1);
        @(negedge clock);
        check("t5_tmo_single", err_timeout_o, 1'b0);
        // back in IDLE: a fresh frame is accepted, 02^01^77 = 74
        send_byte(8'hA5); send_byte(8'h02); send_byte(8'h01);
        send_byte(8'h77); send_byte(8'h74);
        check_pkt("t5", 8'h02, 5'd1, 8'h77, 8'h00);
        ack_pkt("t5");

        // byte on the expiry cycle wins: 01^02^44^55 = 12
        send_byte(8'hA5); send_byte(8'h01);
        repeat (TMO - 2) @(negedge clock);
        send_byte(8'h02);
        check("t6_no_tmo", err_timeout_o, 1'b0);
        send_byte(8'h44); send_byte(8'h55); send_byte(8'h12);
        check_pkt("t6", 8'h01, 5'd2, 8'h44, 8'h55);
        #1 check("t6_tmo_count", cnt_tmo, 1);

        // overrun while held; held packet never times out
        base = cnt_ovr;
        send_byte(8'hA5);
        check("t7_ovr_pulse", err_overrun_o, 1'b1);
        send_byte(8'h00); send_byte(8'h33);
        #1 check("t7_ovr_count3", cnt_ovr - base, 3);
        repeat (TMO + 5) @(negedge clock);
        check_pkt("t7", 8'h01, 5'd2, 8'h44, 8'h55);
        check("t7_no_tmo_in_hold", err_timeout_o, 1'b0);
        @(negedge clock);
        pkt_ack_i    = 1'b1;
        byte_i       = 8'h66;
        byte_valid_i = 1'b1;
        @(negedge clock);
        pkt_ack_i    = 1'b0;
        byte_valid_i = 1'b0;
        check("t7_ovr_on_ack", err_overrun_o, 1'b1);
        check("t7_valid_after_ack", pkt_valid_o, 1'b0);
        #1 check("t7_ovr_count4", cnt_ovr - base, 4);

        // reset mid-payload
        send_byte(8'hA5); send_byte(8'h10); send_byte(8'h02); send_byte(8'h11);
        @(negedge clock);
        reset_n = 1'b0;
        #1;
        check("t8_rst_valid", pkt_valid_o, 1'b0);
        check("t8_rst_cmd", pkt_cmd_o, 8'h00);
        check("t8_rst_len", pkt_len_o, 5'd0);
        check("t8_rst_rd", rd_data_o, 8'h00);
        check("t8_rst_errs", {err_checksum_o, err_length_o, err_timeout_o, err_overrun_o}, 4'b0000);
        @(negedge clock);
        reset_n = 1'b1;
        send_byte(8'hA5); send_byte(8'h10); send_byte(8'h02);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h21);
        check_pkt("t8", 8'h10, 5'd2, 8'h11, 8'h22);
        ack_pkt("t8");
        #1;
        check("final_chk_count", cnt_chk, 1);
        check("final_tmo_count", cnt_tmo, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
